i2c_target_regfile: RTL

Synthesizable I2C target (slave) that responds to the IICMB controller's transactions on one bus. It decodes the 7-bit address and exposes a byte-wide register file through a pointer-based protocol: the first written byte sets the pointer, and further bytes are written or read with auto-increment. The block serves as the RTL responder end of the I2C bus and as a reference DUT for controller-side tests. It also provides a local side port for inspecting writes.

---
 rtl/i2c_target_regfile.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a pointer-addressed byte register file with auto-increment.
// Optional general-call reset (address 0x00, data 0x06) when I2C_TGT_GEN_CALL_EN is defined.
module i2c_target_regfile #(
   parameter int                        I2C_ADDR_WIDTH  = 7,
   parameter logic [I2C_ADDR_WIDTH-1:0] I2C_DEVICE_ADDR = 7'h22,
   parameter int                        REG_DEPTH       = 16,
   parameter int                        PTR_WIDTH       = $clog2(REG_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 scl_o,
   output logic                 sda_o,
   output logic                 wr_valid_o,
   output logic [PTR_WIDTH-1:0] wr_addr_o,
   output logic [7:0]           wr_data_o,
   output logic                 busy_o,
   input  logic [PTR_WIDTH-1:0] rd_addr_i,
   output logic [7:0]           rd_data_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK
   } state_t;

   state_t               state_q;
   logic [2:0]           scl_q, sda_q;
   logic [7:0]           sr_q;
   logic [3:0]           cnt_q;
   logic                 rw_q;
   logic [PTR_WIDTH-1:0] ptr_q;
   logic [7:0]           regs_q [REG_DEPTH];
   logic                 sda_o_q, busy_q, wr_valid_q;
   logic [PTR_WIDTH-1:0] wr_addr_q;
   logic [7:0]           wr_data_q;
`ifdef I2C_TGT_GEN_CALL_EN
   logic                 gc_q;
`endif

   logic                 scl_rise, scl_fall, start_det, stop_det, addr_match;
   logic [PTR_WIDTH-1:0] ptr_d;

   // Bits [0],[1] are the synchronizer, bit [2] is the history flop.
   assign scl_rise   =  scl_q[1] & ~scl_q[2];
   assign scl_fall   = ~scl_q[1] &  scl_q[2];
   assign start_det  =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
   assign stop_det   =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
   assign addr_match = (sr_q[7 -: I2C_ADDR_WIDTH] == I2C_DEVICE_ADDR);
   assign ptr_d      = ptr_q + PTR_WIDTH'(1);

   assign scl_o      = 1'b1;
   assign sda_o      = sda_o_q;
   assign busy_o     = busy_q;
   assign wr_valid_o = wr_valid_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign rd_data_o  = regs_q[rd_addr_i];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         scl_q      <= 3'b111;
         sda_q      <= 3'b111;
         sr_q       <= '0;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         ptr_q      <= '0;
         sda_o_q    <= 1'b1;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef I2C_TGT_GEN_CALL_EN
         gc_q       <= 1'b0;
`endif
         for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
      end else begin
         scl_q      <= {scl_q[1:0], scl_i};
         sda_q      <= {sda_q[1:0], sda_i};
         wr_valid_q <= 1'b0;
         if (start_det) begin
            state_q <= ADDR;
            cnt_q   <= '0;
            sda_o_q <= 1'b1;
`ifdef I2C_TGT_GEN_CALL_EN
            gc_q    <= 1'b0;
`endif
         end else if (stop_det) begin
            state_q <= IDLE;
            sda_o_q <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: ;
               ADDR, PTR, WR: begin
                  if (scl_rise && cnt_q != 4'd8) begin
                     sr_q  <= {sr_q[6:0], sda_q[1]};
                     cnt_q <= cnt_q + 4'd1;
                  end else if (scl_fall && cnt_q == 4'd8) begin
                     // Byte complete: ACK is driven from the falling edge after bit 8.
                     if (state_q == ADDR) begin
                        if (addr_match) begin
                           busy_q  <= 1'b1;
                           sda_o_q <= 1'b0;
                           rw_q    <= sr_q[0];
                           state_q <= ADDR_ACK;
`ifdef I2C_TGT_GEN_CALL_EN
                        end else if (sr_q == 8'h00) begin
                           busy_q  <= 1'b1;
                           sda_o_q <= 1'b0;
                           rw_q    <= 1'b0;
                           gc_q    <= 1'b1;
                           state_q <= ADDR_ACK;
`endif
                        end else begin
                           state_q <= IDLE;
                        end
                     end else if (state_q == PTR) begin
                        sda_o_q <= 1'b0;
                        state_q <= PTR_ACK;
`ifdef I2C_TGT_GEN_CALL_EN
                        if (gc_q) begin
                           if (sr_q == 8'h06) begin
                              ptr_q <= '0;
                              for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
                           end
                        end else begin
                           ptr_q <= sr_q[PTR_WIDTH-1:0];
                        end
`else
                        ptr_q <= sr_q[PTR_WIDTH-1:0];
`endif
                     end else begin
                        sda_o_q       <= 1'b0;
                        regs_q[ptr_q] <= sr_q;
                        wr_valid_q    <= 1'b1;
                        wr_addr_q     <= ptr_q;
                        wr_data_q     <= sr_q;
                        ptr_q         <= ptr_d;
                        state_q       <= WR_ACK;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!rw_q) begin
                        sda_o_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= PTR;
                     end else begin
                        sda_o_q <= regs_q[ptr_q][7];
                        sr_q    <= {regs_q[ptr_q][6:0], 1'b0};
                        cnt_q   <= 4'd1;
                        state_q <= RD;
                     end
                  end
               end
               PTR_ACK: begin
                  if (scl_fall) begin
                     sda_o_q <= 1'b1;
                     cnt_q   <= '0;
`ifdef I2C_TGT_GEN_CALL_EN
                     if (gc_q) begin
                        gc_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        state_q <= WR;
                     end
`else
                     state_q <= WR;
`endif
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_o_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= WR;
                  end
               end
               RD: begin
                  if (scl_fall) begin
                     if (cnt_q == 4'd8) begin
                        sda_o_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= RD_ACK;
                     end else begin
                        sda_o_q <= sr_q[7];
                        sr_q    <= {sr_q[6:0], 1'b0};
                        cnt_q   <= cnt_q + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_q[1]) begin
                        sr_q    <= regs_q[ptr_q];
                        cnt_q   <= '0;
                        state_q <= RD;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
